// File: rtl/timer_bank.sv
// timer_bank: NUM_TIMERS programmable up-counters sharing one prescaler.
// Each timer has a preload, start, mask and one-shot/auto-reload mode. It
// raises a one-cycle overflow pulse and a sticky flag, and the flags drive
// the status byte and the active-low IRQ.
module timer_bank #(
  parameter int         NUM_TIMERS      = 2,
  parameter int         COUNT_WIDTH     = 8,
  parameter int         TICK_DIV        = 256,
  parameter int         RATIO_LOG2      = 2,
  parameter logic [7:0] TIMER_BASE_ADDR = 8'h02,
  parameter logic [7:0] CTRL_ADDR       = 8'h04,
  parameter logic [7:0] MODE_ADDR       = 8'h05
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              wr_valid,
  input  logic [7:0]                        wr_addr,
  input  logic [7:0]                        wr_data,
  input  logic [NUM_TIMERS-1:0]             force_overflow,
  output logic                              irq_n,
  output logic [7:0]                        status,
  output logic [NUM_TIMERS-1:0]             overflow_pulse,
  output logic [NUM_TIMERS*COUNT_WIDTH-1:0] count
);

  localparam int PRE_W = $clog2(TICK_DIV);
  localparam int SUB_W = ((NUM_TIMERS - 1) * RATIO_LOG2 > 0) ? (NUM_TIMERS - 1) * RATIO_LOG2 : 1;
  localparam logic [COUNT_WIDTH-1:0] ALL_ONES = '1;

  logic [PRE_W-1:0]      prescaler;
  logic                  base_tick;
  logic                  ctrl_wr;
  logic                  irq_clr;
  logic                  mode_wr;
  logic [NUM_TIMERS-1:0] flag;

  assign ctrl_wr   = wr_valid && (wr_addr == CTRL_ADDR);
  assign irq_clr   = ctrl_wr && wr_data[7];
  assign mode_wr   = wr_valid && (wr_addr == MODE_ADDR);
  assign base_tick = (prescaler == PRE_W'(TICK_DIV - 1));

  // Free-running prescaler, wraps after TICK_DIV-1
  always_ff @(posedge clk) begin
    if (reset)          prescaler <= '0;
    else if (base_tick) prescaler <= '0;
    else                prescaler <= prescaler + 1'b1;
  end

  for (genvar g = 0; g < NUM_TIMERS; g++) begin : g_timer
    localparam logic [7:0]       PRELOAD_ADDR = TIMER_BASE_ADDR + 8'(g);
    localparam logic [SUB_W-1:0] SUB_MAX      = SUB_W'((1 << (g * RATIO_LOG2)) - 1);

    logic                   start_r, start_q, mask_r, mode_r, flag_r, pulse_r;
    logic                   run, tick, wrap;
    logic [COUNT_WIDTH-1:0] preload_r, cnt_r;
    logic [SUB_W-1:0]       sub_r;

    // The start-edge cycle only loads; counting begins the cycle after.
    assign run  = start_r & start_q;
    assign tick = run & base_tick & (sub_r == SUB_MAX);
    assign wrap = tick & (cnt_r == ALL_ONES);

    // Preload register; a write while running only matters at the next load
    always_ff @(posedge clk) begin
      if (reset)                                    preload_r <= '0;
      else if (wr_valid && wr_addr == PRELOAD_ADDR) preload_r <= wr_data[COUNT_WIDTH-1:0];
    end

    // Control bits; a host CTRL write overrides the one-shot self-stop
    always_ff @(posedge clk) begin
      if (reset) begin
        start_r <= 1'b0;
        start_q <= 1'b0;
        mask_r  <= 1'b0;
        mode_r  <= 1'b0;
      end else begin
        start_q <= start_r;
        if (ctrl_wr && !wr_data[7]) begin
          start_r <= wr_data[g];
          mask_r  <= wr_data[6-g];
        end else if (wrap && mode_r) begin
          start_r <= 1'b0;
        end
        if (mode_wr) mode_r <= wr_data[g];
      end
    end

    // Sub-counter divides base ticks; counter loads on start edge, reloads on overflow
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_r <= '0;
        sub_r <= '0;
      end else if (start_r && !start_q) begin
        cnt_r <= preload_r;
        sub_r <= '0;
      end else if (run && base_tick) begin
        if (sub_r == SUB_MAX) begin
          sub_r <= '0;
          cnt_r <= wrap ? preload_r : cnt_r + 1'b1;
        end else begin
          sub_r <= sub_r + 1'b1;
        end
      end
    end

    // Registered overflow pulse
    always_ff @(posedge clk) begin
      if (reset) pulse_r <= 1'b0;
      else       pulse_r <= wrap;
    end

    // Sticky flag; IRQ reset wins over a simultaneous set
    always_ff @(posedge clk) begin
      if (reset)                                       flag_r <= 1'b0;
      else if (irq_clr)                                flag_r <= 1'b0;
      else if ((pulse_r | force_overflow[g]) & ~mask_r) flag_r <= 1'b1;
    end

    assign flag[g]                                  = flag_r;
    assign overflow_pulse[g]                        = pulse_r;
    assign count[g*COUNT_WIDTH +: COUNT_WIDTH]      = cnt_r;
  end

  assign status[7] = |flag;
  for (genvar b = 0; b < 7; b++) begin : g_status
    if (6 - b < NUM_TIMERS) begin : g_flag_bit
      assign status[b] = flag[6-b];
    end else begin : g_zero_bit
      assign status[b] = 1'b0;
    end
  end

  // Active-low IRQ follows the flags one cycle later
  always_ff @(posedge clk) begin
    if (reset) irq_n <= 1'b1;
    else       irq_n <= ~(|flag);
  end

endmodule

// File: tb/tb_timer_bank.sv
// Testbench for timer_bank: a reference model steps on each clk edge and
// queues the expected outputs; a monitor pops and compares on the falling edge.
module tb_timer_bank;

  localparam int NT = 2;
  localparam int CW = 8;
  localparam int TD = 4;
  localparam int RL = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              wr_valid = 1'b0;
  logic [7:0]        wr_addr = 8'h00;
  logic [7:0]        wr_data = 8'h00;
  logic [NT-1:0]     force_overflow = '0;
  logic              irq_n;
  logic [7:0]        status;
  logic [NT-1:0]     overflow_pulse;
  logic [NT*CW-1:0]  count;

  timer_bank #(
    .NUM_TIMERS(NT), .COUNT_WIDTH(CW), .TICK_DIV(TD), .RATIO_LOG2(RL),
    .TIMER_BASE_ADDR(8'h02), .CTRL_ADDR(8'h04), .MODE_ADDR(8'h05)
  ) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_addr(wr_addr),
    .wr_data(wr_data), .force_overflow(force_overflow), .irq_n(irq_n),
    .status(status), .overflow_pulse(overflow_pulse), .count(count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [NT*CW-1:0] count;
    logic [7:0]       status;
    logic             irq_n;
    logic [NT-1:0]    pulse;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state
  int m_pre = 0;
  int m_preload[NT], m_cnt[NT], m_sub[NT];
  bit m_start[NT], m_prev[NT], m_mask[NT], m_mode[NT], m_flag[NT], m_pulse[NT];
  bit m_irq_n = 1'b1;

  function automatic bit bit_of(input logic [7:0] v, input int i);
    return ((v >> i) & 8'h01) != 8'h00;
  endfunction

  task automatic model_step();
    int nc[NT];
    int ns[NT];
    bit nst[NT];
    bit npulse[NT];
    bit nflag[NT];
    bit base, ctrl, clr, any_flag;
    int ratio;
    if (reset) begin
      m_pre = 0;
      m_irq_n = 1'b1;
      for (int i = 0; i < NT; i++) begin
        m_preload[i] = 0; m_cnt[i] = 0; m_sub[i] = 0; m_start[i] = 0; m_prev[i] = 0;
        m_mask[i] = 0; m_mode[i] = 0; m_flag[i] = 0; m_pulse[i] = 0;
      end
    end else begin
      base = (m_pre == TD - 1);
      ctrl = wr_valid && wr_addr == 8'h04;
      clr  = ctrl && wr_data[7];
      any_flag = 1'b0;
      for (int i = 0; i < NT; i++) begin
        ratio = 1 << (i * RL);
        nc[i] = m_cnt[i];
        ns[i] = m_sub[i];
        nst[i] = m_start[i];
        npulse[i] = 1'b0;
        if (m_start[i] && !m_prev[i]) begin
          nc[i] = m_preload[i];
          ns[i] = 0;
        end else if (m_start[i] && m_prev[i] && base) begin
          ns[i] = m_sub[i] + 1;
          if (ns[i] == ratio) begin
            ns[i] = 0;
            if (m_cnt[i] == (1 << CW) - 1) begin
              npulse[i] = 1'b1;
              nc[i] = m_preload[i];
              if (m_mode[i]) nst[i] = 1'b0;
            end else begin
              nc[i] = m_cnt[i] + 1;
            end
          end
        end
        any_flag |= m_flag[i];
        nflag[i] = clr ? 1'b0
                 : (m_flag[i] | ((m_pulse[i] | bit_of(8'(force_overflow), i)) & !m_mask[i]));
      end
      for (int i = 0; i < NT; i++) begin
        m_prev[i] = m_start[i];
        if (ctrl && !wr_data[7]) begin
          nst[i] = bit_of(wr_data, i);
          m_mask[i] = bit_of(wr_data, 6 - i);
        end
        if (wr_valid && wr_addr == 8'h05) m_mode[i] = bit_of(wr_data, i);
        if (wr_valid && wr_addr == 8'(2 + i)) m_preload[i] = int'(wr_data);
        m_start[i] = nst[i];
        m_cnt[i] = nc[i];
        m_sub[i] = ns[i];
        m_pulse[i] = npulse[i];
        m_flag[i] = nflag[i];
      end
      m_irq_n = !any_flag;
      m_pre = (m_pre + 1) % TD;
    end
  endtask

  // Model advances on every clock edge and queues the expected outputs
  always @(posedge clk) begin
    exp_t e;
    model_step();
    e.count = '0; e.status = 8'h00; e.pulse = '0; e.irq_n = m_irq_n;
    for (int i = 0; i < NT; i++) begin
      e.count = e.count | ((NT*CW)'(m_cnt[i]) << (i * CW));
      e.pulse = e.pulse | (NT'(m_pulse[i]) << i);
      if (m_flag[i]) e.status = e.status | 8'h80 | (8'h40 >> i);
    end
    exp_q.push_back(e);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: compares DUT outputs against the queued expectation each cycle
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("count", 32'(count), 32'(e.count));
      check("status", 32'(status), 32'(e.status));
      check("irq_n", 32'(irq_n), 32'(e.irq_n));
      check("overflow_pulse", 32'(overflow_pulse), 32'(e.pulse));
    end
  end

  int pc0 = 0;
  int pc1 = 0;
  always @(negedge clk) begin
    if (overflow_pulse[0]) pc0++;
    if (overflow_pulse[1]) pc1++;
  end

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting, got no event, expected one", name);
  endtask

  initial begin
    int s;
    bit hit;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Auto-reload on timer 0, preload FE: one pulse per 8 clk
    wr(8'h02, 8'hFE); wr(8'h05, 8'h00); wr(8'h04, 8'h01);
    repeat (16) @(negedge clk);
    @(posedge clk); s = pc0;
    repeat (64) @(posedge clk);
    check("pulse0_per_64clk", 32'(pc0 - s), 32'd8);

    // Ratio: timer 1 ticks every 16 clk, preload FF overflows every tick
    wr(8'h03, 8'hFF); wr(8'h04, 8'h02);
    repeat (20) @(negedge clk);
    @(posedge clk); s = pc1;
    repeat (64) @(posedge clk);
    check("pulse1_per_64clk", 32'(pc1 - s), 32'd4);

    // One-shot on timer 0
    wr(8'h04, 8'h00); wr(8'h05, 8'h01); wr(8'h02, 8'hFF);
    repeat (4) @(negedge clk);
    @(posedge clk); s = pc0;
    wr(8'h04, 8'h01);
    repeat (420) @(negedge clk);
    check("oneshot_pulses", 32'(pc0 - s), 32'd1);
    check("oneshot_hold", 32'(count[7:0]), 32'hFF);

    // Mask timer 0 while it overflows, then force timer 1
    wr(8'h04, 8'h80); wr(8'h05, 8'h00); wr(8'h02, 8'hFE); wr(8'h04, 8'h00);
    wr(8'h04, 8'h41);
    repeat (40) @(negedge clk);
    @(negedge clk); force_overflow = 2'b10;
    @(negedge clk); force_overflow = 2'b00;
    repeat (4) @(negedge clk);

    // IRQ reset landing on the same cycle as an overflow pulse
    wr(8'h04, 8'h01);
    repeat (20) @(negedge clk);
    hit = 1'b0;
    for (int k = 0; k < 64 && !hit; k++) begin
      @(negedge clk);
      if (overflow_pulse[0]) begin
        hit = 1'b1;
        wr_valid = 1'b1; wr_addr = 8'h04; wr_data = 8'h80;
        @(negedge clk);
        wr_valid = 1'b0;
      end
    end
    if (!hit) timeout_fail("irq_clear_coincide");
    repeat (4) @(negedge clk);

    // Reset while timer 0 is mid-count at 0x80
    wr(8'h04, 8'h00); wr(8'h02, 8'h70); wr(8'h04, 8'h01);
    hit = 1'b0;
    for (int k = 0; k < 1000 && !hit; k++) begin
      @(negedge clk);
      if (count[7:0] == 8'h80) hit = 1'b1;
    end
    if (!hit) timeout_fail("reach_0x80");
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);

    // Randomized register traffic, forced overflows and occasional resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 499) == 0);
      force_overflow = ($urandom_range(0, 19) == 0) ? NT'($urandom) : '0;
      wr_valid = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 5))
        0, 1: begin wr_addr = 8'(8'h02 + $urandom_range(0, 1)); wr_data = 8'($urandom_range(8'hE0, 8'hFF)); end
        2, 3: begin wr_addr = 8'h04; wr_data = 8'($urandom); if ($urandom_range(0, 3) != 0) wr_data[7] = 1'b0; end
        4:    begin wr_addr = 8'h05; wr_data = 8'($urandom); end
        default: begin wr_addr = 8'($urandom); wr_data = 8'($urandom); end
      endcase
    end
    @(negedge clk);
    reset = 1'b0; wr_valid = 1'b0; force_overflow = '0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/timer_bank.md
Name: timer_bank

Overview:
- Parametrised successor to the two-timer OPL2 timer block: NUM_TIMERS programmable up-counters with per-timer preload, start, mask and new one-shot/auto-reload mode.
- Shared prescaler with per-timer power-of-two tick ratios.
- Sits beside the register file on the synth clock domain. Consumes the same register-write strobe. Drives the status byte and the active-low IRQ.
- Host-side CDC stays outside this block.

Parameters:
- NUM_TIMERS, 2, timer count, legal 1..3.
- COUNT_WIDTH, 8, counter/preload width, legal 1..8.
- TICK_DIV, 256, clk cycles per base tick, legal >=2.
- RATIO_LOG2, 2, timer i advances once per 2^(i*RATIO_LOG2) base ticks.
- TIMER_BASE_ADDR, 8'h02, preload register of timer i at TIMER_BASE_ADDR+i.
- CTRL_ADDR, 8'h04, control register address.
- MODE_ADDR, 8'h05, mode register address.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- wr_valid  in  1  register write strobe, one cycle
- wr_addr  in  8  write address
- wr_data  in  8  write data
- force_overflow  in  NUM_TIMERS  per-timer forced overflow request, level-sampled each cycle
- irq_n  out  1  registered active-low interrupt
- status  out  8  combinational status byte
- overflow_pulse  out  NUM_TIMERS  one-cycle overflow pulse per timer, registered
- count  out  NUM_TIMERS*COUNT_WIDTH  live counter values, timer i at [i*COUNT_WIDTH +: COUNT_WIDTH]

Behaviour:
- Reset is reset, synchronous, active-high; clock is clk.
- Reset values:
  - preload, count, start, mask, mode, flags, sub-counters, prescaler and overflow_pulse are all 0.
  - irq_n = 1; status = 0.
- Register writes take effect the cycle after wr_valid:
  - Preload write: preload[i] <= wr_data[COUNT_WIDTH-1:0].
  - CTRL write with wr_data[7]=1: IRQ reset only. All flags clear next cycle; start and mask bits are untouched.
  - CTRL write with wr_data[7]=0:
    - start[i] <= wr_data[i].
    - mask[i] <= wr_data[6-i].
  - MODE write: mode[i] <= wr_data[i] (1 = one-shot, 0 = auto-reload).
  - Unmapped addresses are ignored.
- Prescaler:
  - Free-running 0..TICK_DIV-1, never stops except on reset.
  - base_tick is asserted in the cycle the prescaler equals TICK_DIV-1.
- Timer i tick:
  - Sub-counter counts base_ticks.
  - tick_i is asserted on the base_tick where the sub-counter equals 2^(i*RATIO_LOG2)-1; the sub-counter then wraps to 0.
  - With i=0 every base_tick is a tick.
- Start edge: on start[i] 0->1, count <= preload and sub-counter <= 0. The first tick is counted afterwards.
- Stop: start 1->0 freezes count and sub-counter.
- Running, on tick_i:
  - If count == all-ones: overflow_pulse[i] fires next cycle and count <= preload.
    - One-shot mode: start[i] <= 0.
    - Auto-reload mode: keep running.
  - Otherwise count <= count+1.
- A preload write while running affects only the next reload or start.
- Preload = all-ones: overflow on every tick.
- force_overflow[i] is treated as an overflow event for the flag logic only. It has no effect on count or overflow_pulse.
- Flags:
  - Set: flag[i] <= 1 on (overflow_pulse[i] | force_overflow[i]) & !mask[i].
  - Masking after set does not clear the flag.
  - IRQ reset clear wins over a set in the same cycle.
  - Reset clears all flags.
- status:
  - [7] = |flag.
  - [6-i] = flag[i].
  - All other bits are 0.
- irq_n <= !(|flag), i.e. one-cycle latency from a flag change.
- Reset mid-count: everything returns to reset values. The prescaler restarts at 0.

Test Plan:
- Auto-reload (TICK_DIV=4, RATIO_LOG2=2):
  - Stimulus: preload0=0xFE, MODE=0, CTRL=0x01.
  - Response: count0 reads FE, FF, then back to FE, stepping every 4 clk.
  - overflow_pulse[0] is high for exactly 1 cycle per 8 clk.
  - status=0xC0; irq_n falls 1 cycle after flag0 sets.
- Ratio: preload1=0xFF, CTRL=0x02.
  - overflow_pulse[1] every 16 clk; status=0xA0.
- One-shot: MODE=0x01, preload0=0xFF, CTRL=0x01.
  - A single overflow_pulse[0] fires and start0 clears.
  - count0 holds at 0xFF; there is no second pulse within 100 ticks.
- Mask and force:
  - CTRL=0x41 with timer0 overflowing: no flag set, irq_n stays 1.
  - force_overflow[1]=1 for 1 cycle with mask1=0: status=0xA0.
- IRQ reset precedence:
  - CTRL=0x80 is written so that its clear cycle coincides with an overflow_pulse[0].
  - Response: flags=0, status=0x00, irq_n returns to 1, start/mask unchanged.
- Reset mid-count: reset asserted while count0=0x80 gives count=0, status=0, irq_n=1 and no pulses until restarted.
